// File: rtl/addsub_chunked_if.sv
// Valid/ready operand and result channels of the chunk-serial adder/subtractor.
// The master side issues operands and consumes results. The slave side is the datapath.
interface addsub_chunked_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_cout;
    logic             out_neg;

    modport master (
        output in_valid, in_a, in_b, in_ctl, out_ready,
        input  in_ready, out_valid, out_res, out_cout, out_neg
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ctl, out_ready,
        output in_ready, out_valid, out_res, out_cout, out_neg
    );
endinterface

// File: rtl/addsub_chunked.sv
// Multi-cycle unsigned add / magnitude-subtract. One CHUNK-bit ripple slice is reused N times,
// and a second chunk-serial pass performs the two's-complement fix-up when A < B.
module addsub_chunked #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    addsub_chunked_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("addsub_chunked: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             ctl_q, carry_q, cout_q, neg_q;
    logic [IW-1:0]    idx_q;

    logic [CHUNK:0]       run_sum, neg_sum;
    logic [WIDTH-1:0]     s_run, s_neg;
    logic                 last;

    // Operands are shifted right each chunk, and result chunks enter S from the top,
    // so after N steps chunk 0 sits at the LSB. The concat form also works when CHUNK == WIDTH.
    assign run_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign neg_sum = {1'b0, ~s_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign s_run   = WIDTH'({run_sum[CHUNK-1:0], s_q} >> CHUNK);
    assign s_neg   = WIDTH'({neg_sum[CHUNK-1:0], s_q} >> CHUNK);
    assign last    = (idx_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (last) state_d = (ctl_q && !run_sum[CHUNK]) ? NEG : DONE;
            NEG:  if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == DONE);
        bus.in_ready  = (state_q == IDLE) && !rst;
    end

    assign bus.out_res  = s_q;
    assign bus.out_cout = cout_q;
    assign bus.out_neg  = neg_q;

    // NOTE: non-blocking assignments, so every register samples pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            ctl_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.in_a;
                    b_q     <= bus.in_ctl ? ~bus.in_b : bus.in_b;
                    ctl_q   <= bus.in_ctl;
                    carry_q <= bus.in_ctl;
                    cout_q  <= 1'b0;
                    neg_q   <= 1'b0;
                    idx_q   <= '0;
                end
                RUN: begin
                    a_q <= a_q >> CHUNK;
                    b_q <= b_q >> CHUNK;
                    s_q <= s_run;
                    if (last) begin
                        cout_q  <= run_sum[CHUNK];
                        carry_q <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        carry_q <= run_sum[CHUNK];
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                NEG: begin
                    s_q <= s_neg;
                    if (last) begin
                        neg_q <= 1'b1;
                        idx_q <= '0;
                    end else begin
                        carry_q <= neg_sum[CHUNK];
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_chunked.sv
// Directed checks on an 8/4 instance, plus random sweeps on 8/1, 8/8 and 24/6 instances
// against a behavioural model of result, flags and latency.
module tb_addsub_chunked;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    addsub_chunked_if #(.WIDTH(8)) bus ();
    addsub_chunked #(.WIDTH(8), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands, count edges from accept to out_valid, capture outputs;
    // completes the handshake when out_ready is already high.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ctl,
                         output logic [7:0] res, output logic cout, output logic neg,
                         output int lat);
        int t = 0;
        bus.in_a = a; bus.in_b = b; bus.in_ctl = ctl; bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); @(negedge clk); t++;
        end
        check("in_ready before accept", 32'(bus.in_ready), 1);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        res = bus.out_res; cout = bus.out_cout; neg = bus.out_neg;
        if (bus.out_ready) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int GW = (g == 2) ? 24 : 8;
        localparam int GC = (g == 0) ? 1 : (g == 1) ? 8 : 6;
        localparam int GN = GW / GC;

        addsub_chunked_if #(.WIDTH(GW)) sbus ();
        addsub_chunked #(.WIDTH(GW), .CHUNK(GC)) u_sweep (.clk(clk), .rst(rst), .bus(sbus.slave));

        logic done = 1'b0;

        initial begin : sweep
            logic [GW-1:0] a, b, eres, hres;
            logic [GW:0]   sum;
            logic          ctl, ecout, eneg;
            int            elat, lat, t;
            sbus.in_valid = 1'b0; sbus.in_a = '0; sbus.in_b = '0; sbus.in_ctl = 1'b0;
            sbus.out_ready = 1'b0;
            wait (go);
            @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                a = GW'($urandom); b = GW'($urandom); ctl = 1'($urandom_range(0, 1));
                if (n % 50 == 0) b = a;
                if (!ctl) begin
                    sum = {1'b0, a} + {1'b0, b};
                    eres = sum[GW-1:0]; ecout = sum[GW]; eneg = 1'b0; elat = GN;
                end else if (a >= b) begin
                    eres = a - b; ecout = 1'b1; eneg = 1'b0; elat = GN;
                end else begin
                    eres = b - a; ecout = 1'b0; eneg = 1'b1; elat = 2 * GN;
                end
                sbus.out_ready = 1'($urandom_range(0, 1));
                sbus.in_a = a; sbus.in_b = b; sbus.in_ctl = ctl; sbus.in_valid = 1'b1;
                t = 0;
                while (!sbus.in_ready && t < 50) begin
                    @(posedge clk); @(negedge clk); t++;
                end
                check($sformatf("sweep%0d in_ready", g), 32'(sbus.in_ready), 1);
                @(posedge clk);
                lat = 0;
                @(negedge clk);
                sbus.in_valid = 1'b0;
                while (!sbus.out_valid && lat < 200) begin
                    @(posedge clk); lat++; @(negedge clk);
                end
                check($sformatf("sweep%0d res a=%0h b=%0h ctl=%0d", g, a, b, ctl), 32'(sbus.out_res), 32'(eres));
                check($sformatf("sweep%0d cout", g), 32'(sbus.out_cout), 32'(ecout));
                check($sformatf("sweep%0d neg", g), 32'(sbus.out_neg), 32'(eneg));
                check($sformatf("sweep%0d latency", g), 32'(lat), 32'(elat));
                if (!sbus.out_ready) begin
                    hres = sbus.out_res;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); @(negedge clk);
                    end
                    check($sformatf("sweep%0d held", g), {7'd0, sbus.out_valid, sbus.out_res},
                          {7'd0, 1'b1, hres});
                    sbus.out_ready = 1'b1;
                end
                @(posedge clk); @(negedge clk);
            end
            done = 1'b1;
        end
    end

    initial begin : directed
        logic [7:0] res;
        logic       cout, neg, seen;
        int         lat, t;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_ctl = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset out_res", 32'(bus.out_res), 0);
        check("reset out_cout", 32'(bus.out_cout), 0);
        check("reset out_neg", 32'(bus.out_neg), 0);
        check("reset in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", 32'(bus.in_ready), 1);
        @(negedge clk);

        do_op(8'h3C, 8'h15, 1'b0, res, cout, neg, lat);
        check("add 3C+15 res", 32'(res), 32'h51);
        check("add 3C+15 cout", 32'(cout), 0);
        check("add 3C+15 neg", 32'(neg), 0);
        check("add 3C+15 latency", 32'(lat), 2);

        do_op(8'h15, 8'h3C, 1'b1, res, cout, neg, lat);
        check("sub 15-3C res", 32'(res), 32'h27);
        check("sub 15-3C cout", 32'(cout), 0);
        check("sub 15-3C neg", 32'(neg), 1);
        check("sub 15-3C latency", 32'(lat), 4);

        do_op(8'hFF, 8'h01, 1'b0, res, cout, neg, lat);
        check("add FF+01 res", 32'(res), 32'h00);
        check("add FF+01 cout", 32'(cout), 1);
        check("add FF+01 neg", 32'(neg), 0);

        do_op(8'h80, 8'h80, 1'b1, res, cout, neg, lat);
        check("sub 80-80 res", 32'(res), 32'h00);
        check("sub 80-80 cout", 32'(cout), 1);
        check("sub 80-80 neg", 32'(neg), 0);
        check("sub 80-80 latency", 32'(lat), 2);

        do_op(8'h00, 8'h80, 1'b1, res, cout, neg, lat);
        check("sub 00-80 res", 32'(res), 32'h80);
        check("sub 00-80 cout", 32'(cout), 0);
        check("sub 00-80 neg", 32'(neg), 1);
        check("sub 00-80 latency", 32'(lat), 4);

        // Backpressure: result held for 5 cycles while a competing request is offered.
        bus.out_ready = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, res, cout, neg, lat);
        check("bp first res", 32'(res), 32'h46);
        bus.in_a = 8'h01; bus.in_b = 8'h02; bus.in_ctl = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("bp hold %0d out_valid", i), 32'(bus.out_valid), 1);
            check($sformatf("bp hold %0d res", i), 32'(bus.out_res), 32'h46);
            check($sformatf("bp hold %0d flags", i), {30'd0, bus.out_cout, bus.out_neg}, 0);
            check($sformatf("bp hold %0d in_ready", i), 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp release out_valid", 32'(bus.out_valid), 0);
        check("bp release in_ready", 32'(bus.in_ready), 1);
        do_op(8'h01, 8'h02, 1'b0, res, cout, neg, lat);
        check("bp next res", 32'(res), 32'h03);
        check("bp next latency", 32'(lat), 2);

        // Reset one cycle into NEG of 01-FF.
        bus.in_a = 8'h01; bus.in_b = 8'hFF; bus.in_ctl = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid-NEG out_valid", 32'(bus.out_valid), 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abort out_valid", 32'(bus.out_valid), 0);
        check("abort in_ready during rst", 32'(bus.in_ready), 0);
        check("abort out_res cleared", 32'(bus.out_res), 0);
        rst = 1'b0;
        #1;
        check("abort in_ready after rst", 32'(bus.in_ready), 1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("abort no out_valid", 32'(seen), 0);

        go = 1'b1;
        t = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 90000) begin
            @(posedge clk); t++;
        end
        check("sweeps completed", {29'd0, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
